// File: rtl/periodic_wave_gen.sv
// Periodic test-waveform source (square/saw/triangle/zero) paced by sample_tick, feeding the period detector.
// Optional LFSR dither on the LSB is enabled with `define WAVEGEN_DITHER_EN.
module periodic_wave_gen #(
    parameter int DATA_WIDTH   = 12,
    parameter int PERIOD_WIDTH = 16,
    parameter int MIN_PERIOD   = 2,
    parameter int FRAC         = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          sample_tick,
    input  logic [PERIOD_WIDTH-1:0]       period_in,
    input  logic [1:0]                    wave_sel,
    input  logic [2:0]                    amp_shift,
    output logic signed [DATA_WIDTH-1:0]  data_out,
    output logic                          en,
    output logic                          cycle_start,
    output logic                          busy,
    output logic                          cfg_err
);
    localparam int QW    = DATA_WIDTH + FRAC;
    localparam int ACC_W = DATA_WIDTH + FRAC + 2;
    localparam int CNT_W = $clog2(QW + 1);
    localparam logic [DATA_WIDTH-1:0] AMP_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_ARM, S_RUN} state_t;

    state_t                     state_q, state_d;
    logic [PERIOD_WIDTH-1:0]    period_q, period_d;
    logic [1:0]                 sel_q, sel_d;
    logic [DATA_WIDTH-1:0]      amp_q, amp_d;
    logic [PERIOD_WIDTH-1:0]    rem_q, rem_d;
    logic [QW-1:0]              quo_q, quo_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PERIOD_WIDTH-1:0]    phase_q, phase_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       stop_pending_q, stop_pending_d;
    logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                       en_q, en_d;
    logic                       cycle_start_q, cycle_start_d;
    logic                       cfg_err_q, cfg_err_d;

    logic signed [ACC_W-1:0]    acc_init;
    logic [PERIOD_WIDTH:0]      rem_shift;
    logic [PERIOD_WIDTH:0]      rem_sub;
    logic                       emit;
    logic                       tick_taken;
    logic                       dither_bit;

    assign acc_init = -$signed({2'b00, amp_q, {FRAC{1'b0}}});

`ifdef WAVEGEN_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d     = tick_taken ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
    assign dither_bit = lfsr_q[0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign dither_bit = 1'b0;
`endif

    // saw is the integer part of the accumulator; triangle folds it about zero
    function automatic logic signed [DATA_WIDTH-1:0] wave_sample(
        input logic [1:0]               sel,
        input logic [PERIOD_WIDTH-1:0]  ph,
        input logic signed [ACC_W-1:0]  acc,
        input logic [PERIOD_WIDTH-1:0]  per,
        input logic [DATA_WIDTH-1:0]    amp,
        input logic                     dith
    );
        logic signed [DATA_WIDTH+1:0] a_s, saw, mag, tri_v, res;
        a_s   = $signed({2'b00, amp});
        saw   = $signed(acc[ACC_W-1:FRAC]);
        mag   = (saw < 0) ? -saw : saw;
        tri_v = (mag <<< 1) - a_s;
        if (tri_v > a_s)  tri_v = a_s;
        if (tri_v < -a_s) tri_v = -a_s;
        case (sel)
            2'd0:    res = (ph < (per >> 1)) ? a_s : -a_s;
            2'd1:    res = saw;
            2'd2:    res = tri_v;
            default: res = '0;
        endcase
        if (sel != 2'd3 && dith && res < a_s) res = res + 1'b1;
        return res[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        sel_d          = sel_q;
        amp_d          = amp_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        cnt_d          = cnt_q;
        phase_d        = phase_q;
        acc_d          = acc_q;
        stop_pending_d = stop_pending_q;
        data_out_d     = data_out_q;
        en_d           = en_q;
        cycle_start_d  = 1'b0;
        cfg_err_d      = 1'b0;
        emit           = 1'b0;
        tick_taken     = 1'b0;
        rem_shift      = {rem_q, quo_q[QW-1]};
        rem_sub        = rem_shift - {1'b0, period_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (period_in >= PERIOD_WIDTH'(MIN_PERIOD)) begin
                        period_d       = period_in;
                        sel_d          = wave_sel;
                        amp_d          = AMP_MAX >> amp_shift;
                        rem_d          = '0;
                        quo_d          = {amp_d[DATA_WIDTH-2:0], 1'b0, {FRAC{1'b0}}};
                        cnt_d          = '0;
                        stop_pending_d = 1'b0;
                        state_d        = S_DIVIDE;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_DIVIDE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    if (rem_shift >= {1'b0, period_q}) begin
                        rem_d = rem_sub[PERIOD_WIDTH-1:0];
                        quo_d = {quo_q[QW-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[PERIOD_WIDTH-1:0];
                        quo_d = {quo_q[QW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(QW - 1)) state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (sample_tick) begin
                    tick_taken    = 1'b1;
                    phase_d       = '0;
                    acc_d         = acc_init;
                    cycle_start_d = 1'b1;
                    emit          = 1'b1;
                    state_d       = S_RUN;
                end
            end
            default: begin
                if (stop) stop_pending_d = 1'b1;
                if (sample_tick) begin
                    tick_taken = 1'b1;
                    if (phase_q == period_q - 1'b1) begin
                        if (stop_pending_q) begin
                            data_out_d     = '0;
                            en_d           = 1'b0;
                            stop_pending_d = 1'b0;
                            state_d        = S_IDLE;
                        end else begin
                            phase_d       = '0;
                            acc_d         = acc_init;
                            cycle_start_d = 1'b1;
                            emit          = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                        acc_d   = acc_q + $signed({2'b00, quo_q});
                        emit    = 1'b1;
                    end
                end
            end
        endcase

        if (emit) begin
            data_out_d = wave_sample(sel_q, phase_d, acc_d, period_q, amp_q, dither_bit);
            en_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            period_q       <= '0;
            sel_q          <= '0;
            amp_q          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            cnt_q          <= '0;
            phase_q        <= '0;
            acc_q          <= '0;
            stop_pending_q <= 1'b0;
            data_out_q     <= '0;
            en_q           <= 1'b0;
            cycle_start_q  <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            period_q       <= period_d;
            sel_q          <= sel_d;
            amp_q          <= amp_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            cnt_q          <= cnt_d;
            phase_q        <= phase_d;
            acc_q          <= acc_d;
            stop_pending_q <= stop_pending_d;
            data_out_q     <= data_out_d;
            en_q           <= en_d;
            cycle_start_q  <= cycle_start_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    assign data_out    = data_out_q;
    assign en          = en_q;
    assign cycle_start = cycle_start_q;
    assign cfg_err     = cfg_err_q;
    assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_periodic_wave_gen.sv
// Scoreboard bench for periodic_wave_gen: each sample_tick pushes the expected sample, popped when the DUT updates.
module tb_periodic_wave_gen;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic               sample_tick;
    logic [15:0]        period_in;
    logic [1:0]         wave_sel;
    logic [2:0]         amp_shift;
    logic signed [11:0] data_out;
    logic               en;
    logic               cycle_start;
    logic               busy;
    logic               cfg_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        int data;
        int en;
        int cs;
    } exp_t;
    exp_t sb_q[$];

    periodic_wave_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .sample_tick (sample_tick),
        .period_in   (period_in),
        .wave_sel    (wave_sel),
        .amp_shift   (amp_shift),
        .data_out    (data_out),
        .en          (en),
        .cycle_start (cycle_start),
        .busy        (busy),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int d, input int e, input int c);
        exp_t x;
        x.data = d;
        x.en   = e;
        x.cs   = c;
        sb_q.push_back(x);
    endtask

    // One tick, then compare the DUT's registered update against the oldest expectation
    task automatic tick_check(input string tag, input int gap);
        exp_t x;
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 1, 0);
        end else begin
            x = sb_q.pop_front();
            check_eq({tag, "_data"}, int'($signed(data_out)), x.data);
            check_eq({tag, "_en"}, int'(en), x.en);
            check_eq({tag, "_cs"}, int'(cycle_start), x.cs);
            $display("tick %s: data_out=%0d en=%0d cycle_start=%0d", tag, $signed(data_out), en, cycle_start);
        end
        repeat (gap - 2) @(negedge clk);
    endtask

    task automatic pulse_start(input int p, input int sel, input int sh, input logic with_stop);
        @(negedge clk);
        period_in = 16'(p);
        wave_sel  = 2'(sel);
        amp_shift = 3'(sh);
        start     = 1'b1;
        stop      = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    initial begin
        int saw_tab[4];
        int tri_tab[4];
        saw_tab = '{-2047, -1024, 0, 1023};
        tri_tab = '{1023, 1, -1023, -1};
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; sample_tick = 1'b0;
        period_in = '0; wave_sel = '0; amp_shift = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_data", int'($signed(data_out)), 0);
        check_eq("rst_en", int'(en), 0);
        check_eq("rst_cs", int'(cycle_start), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_cfg_err", int'(cfg_err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // square P=8; a tick during DIVIDE must be ignored
        pulse_start(8, 0, 0, 1'b0);
        check_eq("sq_busy_after_start", int'(busy), 1);
        sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        check_eq("sq_divide_tick_en", int'(en), 0);
        repeat (35) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            push_exp(((k % 8) < 4) ? 2047 : -2047, 1, ((k % 8) == 0) ? 1 : 0);
            tick_check($sformatf("sq_%0d", k), 20);
        end

        // stop after phase 3: phases 4..7 still emitted, then a terminating tick
        pulse_stop();
        check_eq("stop_busy_held", int'(busy), 1);
        for (int k = 4; k < 8; k++) begin
            push_exp(-2047, 1, 0);
            tick_check($sformatf("stop_ph%0d", k), 20);
        end
        push_exp(0, 0, 0);
        tick_check("stop_end", 20);
        check_eq("stop_busy_low", int'(busy), 0);

        // start+stop together in IDLE: start wins; sawtooth P=4
        pulse_start(4, 1, 0, 1'b1);
        check_eq("saw_busy", int'(busy), 1);
        repeat (35) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            push_exp(saw_tab[k % 4], 1, ((k % 4) == 0) ? 1 : 0);
            tick_check($sformatf("saw_%0d", k), 20);
        end

        // asynchronous reset in the middle of a RUN
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_eq("arst_data", int'($signed(data_out)), 0);
        check_eq("arst_en", int'(en), 0);
        check_eq("arst_busy", int'(busy), 0);
        @(negedge clk) rst_n = 1'b1;
        push_exp(0, 0, 0);
        tick_check("arst_no_output", 10);
        check_eq("arst_busy_after", int'(busy), 0);

        // rejected period, then the smallest legal one
        pulse_start(1, 0, 0, 1'b0);
        check_eq("cfg_err_pulse", int'(cfg_err), 1);
        check_eq("cfg_err_busy", int'(busy), 0);
        check_eq("cfg_err_en", int'(en), 0);
        @(negedge clk);
        check_eq("cfg_err_clear", int'(cfg_err), 0);
        pulse_start(2, 0, 0, 1'b0);
        check_eq("p2_busy", int'(busy), 1);
        check_eq("p2_no_cfg_err", int'(cfg_err), 0);
        repeat (35) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            push_exp(((k % 2) == 0) ? 2047 : -2047, 1, ((k % 2) == 0) ? 1 : 0);
            tick_check($sformatf("p2_%0d", k), 20);
        end
        pulse_stop();
        push_exp(0, 0, 0);
        tick_check("p2_stop_end", 20);

        // stop during DIVIDE aborts without output
        pulse_start(4, 2, 1, 1'b0);
        pulse_stop();
        check_eq("div_stop_busy", int'(busy), 0);
        check_eq("div_stop_en", int'(en), 0);

        // triangle P=4, A=1023
        pulse_start(4, 2, 1, 1'b0);
        repeat (35) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            push_exp(tri_tab[k % 4], 1, ((k % 4) == 0) ? 1 : 0);
            tick_check($sformatf("tri_%0d", k), 20);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
